// File: rtl/readout_arbiter_pkg.sv
// Shared definitions for the readout arbiter and its round-robin picker.
package readout_arbiter_pkg;

  localparam int WORD_W  = 16;
  localparam int MAX_NCH = 64;
  localparam int GNT_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/readout_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: finds the first set bit of
// i_eligible starting at i_start and wrapping modulo NCH.
module rr_pick
  import readout_arbiter_pkg::*;
#(
  parameter int NCH = 16
) (
  input  logic [NCH-1:0]   i_eligible,
  input  logic [GNT_W-1:0] i_start,
  output logic             o_found,
  output logic [GNT_W-1:0] o_idx
);

  logic [2*NCH-1:0] w_dbl;
  logic [NCH-1:0]   w_rot;
  logic [GNT_W:0]   w_off;
  logic [GNT_W:0]   w_sum;

  // Rotating a doubled copy puts the search start at bit 0.
  assign w_dbl = {i_eligible, i_eligible};
  assign w_rot = NCH'(w_dbl >> i_start);

  always_comb begin
    o_found = 1'b0;
    w_off   = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_found = 1'b1;
        w_off   = (GNT_W + 1)'(j);
      end
    end
  end

  assign w_sum = {1'b0, i_start} + w_off;
  assign o_idx = (w_sum >= (GNT_W + 1)'(NCH)) ? GNT_W'(w_sum - (GNT_W + 1)'(NCH))
                                              : w_sum[GNT_W-1:0];

endmodule

// File: rtl/readout_arbiter.sv
// Round-robin readout arbiter: grants one channel per block, drains it with
// one-cycle ack pulses and forwards words as a valid/first-qualified stream.
module readout_arbiter
  import readout_arbiter_pkg::*;
#(
  parameter int NCH    = 16,
  parameter int MAXLEN = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        enable,
  input  logic [NCH-1:0]        req,
  input  logic [WORD_W*NCH-1:0] din,
  output logic [NCH-1:0]        ack,
  output logic [WORD_W-1:0]     dout,
  output logic                  dvalid,
  output logic                  dfirst,
  input  logic                  dready,
  output logic                  busy,
  output logic [GNT_W-1:0]      gnt,
  output logic                  overlen
);

  localparam int CNT_W = $clog2(MAXLEN + 1);

  state_t              r_state;
  state_t              w_next;
  logic [GNT_W-1:0]    r_gnt;
  logic [GNT_W-1:0]    w_start;
  logic [GNT_W-1:0]    w_pickIdx;
  logic                w_found;
  logic [NCH-1:0]      w_elig;
  logic                w_reqG;
  logic                w_fire;
  logic                w_atMax;
  logic [WORD_W-1:0]   w_word;
  logic                r_first;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W-1:0]   r_dout;
  logic                r_dvalid;
  logic                r_dfirst;

  // r_gnt doubles as the round-robin pointer; the search starts one past it.
  assign w_elig  = req & enable;
  assign w_start = (r_gnt >= GNT_W'(NCH - 1)) ? '0 : r_gnt + 1'b1;
  assign w_atMax = (r_cnt == CNT_W'(MAXLEN));

  rr_pick #(.NCH(NCH)) u_pick (
    .i_eligible (w_elig),
    .i_start    (w_start),
    .o_found    (w_found),
    .o_idx      (w_pickIdx)
  );

  always_comb begin
    w_word = '0;
    w_reqG = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (r_gnt == GNT_W'(k)) begin
        w_word = din[k*WORD_W +: WORD_W];
        w_reqG = req[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_found) w_next = ST_GRANT;
      ST_GRANT: begin
        if (!w_reqG)     w_next = ST_IDLE;
        else if (dready) w_next = ST_WAIT;
      end
      ST_WAIT:  w_next = w_atMax ? ST_IDLE : ST_GRANT;
      default:  w_next = ST_IDLE;
    endcase
  end

  // End of block takes priority over dready, so a dropped req never gets acked.
  always_comb begin
    w_fire  = (r_state == ST_GRANT) && w_reqG && dready;
    overlen = (r_state == ST_WAIT) && w_atMax;
    busy    = (r_state != ST_IDLE);
    ack     = '0;
    for (int k = 0; k < NCH; k++) begin
      ack[k] = w_fire && (r_gnt == GNT_W'(k));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt    <= GNT_W'(NCH - 1);
      r_first  <= 1'b0;
      r_cnt    <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_dfirst <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      r_dfirst <= 1'b0;
      if (r_state == ST_IDLE && w_found) begin
        r_gnt   <= w_pickIdx;
        r_first <= 1'b1;
        r_cnt   <= '0;
      end
      if (w_fire) begin
        r_dout   <= w_word;
        r_dvalid <= 1'b1;
        r_dfirst <= r_first;
        r_first  <= 1'b0;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign dout   = r_dout;
  assign dvalid = r_dvalid;
  assign dfirst = r_dfirst;
  assign gnt    = r_gnt;

endmodule

// File: tb/tb_readout_arbiter.sv
// Directed bench for readout_arbiter: a default build plus a MAXLEN=4 build
// share one behavioural channel model; useSmall selects which one it serves.
module tb_readout_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  enable;
  logic [15:0]  req;
  logic [255:0] din;
  logic         dready;

  logic [15:0] ack1, ack2;
  logic [15:0] dout1, dout2;
  logic        dvalid1, dvalid2, dfirst1, dfirst2;
  logic        busy1, busy2, overlen1, overlen2;
  logic [5:0]  gnt1, gnt2;

  int testsRun = 0;
  int testsFailed = 0;

  bit          useSmall = 1'b0;
  int          remaining[16];
  int          sent[16];
  int          ackCount[16];
  int          sampleIdx, ackTotal, ackViol, overlenCount;
  logic [15:0] ackS, doutS;
  logic        dvalidS, dfirstS, busyS, overlenS;
  logic [5:0]  gntS;
  logic [15:0] outQ[$];
  bit          firstQ[$];
  int          grantQ[$];
  int          ackAt[$];
  int          dvAt[$];
  int          overlenAt[$];
  bit          busyHist[$];

  always #5 clk = ~clk;

  readout_arbiter #(.NCH(16), .MAXLEN(1023)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .din(din),
    .ack(ack1), .dout(dout1), .dvalid(dvalid1), .dfirst(dfirst1),
    .dready(dready), .busy(busy1), .gnt(gnt1), .overlen(overlen1)
  );

  readout_arbiter #(.NCH(16), .MAXLEN(4)) u_dutSmall (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .din(din),
    .ack(ack2), .dout(dout2), .dvalid(dvalid2), .dfirst(dfirst2),
    .dready(dready), .busy(busy2), .gnt(gnt2), .overlen(overlen2)
  );

  function automatic logic [15:0] wordOf(input int j);
    return (j == 0) ? 16'h8555 : 16'(j);
  endfunction

  function automatic bit allDrained();
    for (int k = 0; k < 16; k++) if (remaining[k] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic applyStimulus();
    for (int k = 0; k < 16; k++) begin
      req[k] = (remaining[k] != 0);
      din[k*16 +: 16] = wordOf(sent[k]);
    end
  endtask

  task automatic clearLog();
    sampleIdx = 0; ackTotal = 0; ackViol = 0; overlenCount = 0;
    for (int k = 0; k < 16; k++) ackCount[k] = 0;
    outQ.delete(); firstQ.delete(); grantQ.delete(); ackAt.delete();
    dvAt.delete(); overlenAt.delete(); busyHist.delete();
  endtask

  task automatic doReset();
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin remaining[k] = 0; sent[k] = 0; end
    applyStimulus();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One clock: sample outputs on the falling edge, then let the channels react to ack.
  task automatic cycle();
    @(negedge clk);
    ackS     = useSmall ? ack2     : ack1;
    doutS    = useSmall ? dout2    : dout1;
    dvalidS  = useSmall ? dvalid2  : dvalid1;
    dfirstS  = useSmall ? dfirst2  : dfirst1;
    busyS    = useSmall ? busy2    : busy1;
    overlenS = useSmall ? overlen2 : overlen1;
    gntS     = useSmall ? gnt2     : gnt1;
    if (dvalidS) begin
      outQ.push_back(doutS); firstQ.push_back(dfirstS); dvAt.push_back(sampleIdx);
    end
    if (dvalidS && dfirstS) grantQ.push_back(int'(gntS));
    if (ackS != 16'd0) begin ackTotal++; ackAt.push_back(sampleIdx); end
    if (!$onehot0(ackS) || (ackS != 16'd0 && ackS != (16'd1 << gntS))) ackViol++;
    if (overlenS) begin overlenCount++; overlenAt.push_back(outQ.size()); end
    busyHist.push_back(busyS);
    sampleIdx++;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      if (ackS[k]) begin remaining[k]--; sent[k]++; ackCount[k]++; end
    end
    applyStimulus();
  endtask

  task automatic drain(input int budget, output bit timedOut);
    timedOut = 1'b1;
    for (int n = 0; n < budget; n++) begin
      cycle();
      if (allDrained() && !busyS) begin timedOut = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    doReset();
    testsRun++; if (ack1 !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_ack got %h want 0000", ack1); end
    testsRun++; if (dvalid1 !== 1'b0 || dfirst1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_dvalid got %b%b want 00", dvalid1, dfirst1); end
    testsRun++; if (busy1 !== 1'b0 || overlen1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b%b want 00", busy1, overlen1); end
    testsRun++; if (gnt1 !== 6'd15 || gnt2 !== 6'd15) begin testsFailed++; $display("[TB] FAIL reset_gnt got %0d/%0d want 15", gnt1, gnt2); end
    testsRun++; if (dout1 !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_dout got %h want 0000", dout1); end
  endtask

  task automatic test_single_channel();
    clearLog();
    remaining[3] = 4; sent[3] = 0;
    applyStimulus();
    repeat (11) cycle();
    // Sample 0 is IDLE with req just raised; acks land on samples 1,3,5,7.
    testsRun++; if (ackAt.size() !== 4) begin testsFailed++; $display("[TB] FAIL single_ack_count got %0d want 4", ackAt.size()); end
    for (int i = 0; i < 4; i++) begin
      testsRun++; if (ackAt[i] !== 2*i + 1) begin testsFailed++; $display("[TB] FAIL single_ack_time[%0d] got %0d want %0d", i, ackAt[i], 2*i + 1); end
      testsRun++; if (dvAt[i] !== 2*i + 2) begin testsFailed++; $display("[TB] FAIL single_dvalid_time[%0d] got %0d want %0d", i, dvAt[i], 2*i + 2); end
      testsRun++; if (outQ[i] !== wordOf(i)) begin testsFailed++; $display("[TB] FAIL single_word[%0d] got %h want %h", i, outQ[i], wordOf(i)); end
      testsRun++; if (firstQ[i] !== (i == 0)) begin testsFailed++; $display("[TB] FAIL single_first[%0d] got %b want %b", i, firstQ[i], i == 0); end
    end
    testsRun++; if (busyHist[9] !== 1'b1 || busyHist[10] !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_busy_fall got %b%b want 10", busyHist[9], busyHist[10]); end
    testsRun++; if (ackCount[3] !== 4) begin testsFailed++; $display("[TB] FAIL single_ack_ch3 got %0d want 4", ackCount[3]); end
  endtask

  task automatic test_round_robin();
    bit rereqDone = 1'b0;
    bit timedOut = 1'b1;
    doReset();
    clearLog();
    remaining[0] = 2; remaining[5] = 2; remaining[9] = 2;
    applyStimulus();
    for (int n = 0; n < 200; n++) begin
      cycle();
      if (!rereqDone && busyS && gntS == 6'd5) begin
        remaining[0] = 2; sent[0] = 0; rereqDone = 1'b1;
        applyStimulus();
      end
      if (rereqDone && allDrained() && !busyS) begin timedOut = 1'b0; break; end
    end
    testsRun++; if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL rr_timeout got 1 want 0"); end
    testsRun++; if (grantQ.size() !== 4) begin testsFailed++; $display("[TB] FAIL rr_grant_count got %0d want 4", grantQ.size()); end
    testsRun++; if (grantQ[0] !== 0 || grantQ[1] !== 5 || grantQ[2] !== 9 || grantQ[3] !== 0) begin
      testsFailed++; $display("[TB] FAIL rr_order got %0d,%0d,%0d,%0d want 0,5,9,0", grantQ[0], grantQ[1], grantQ[2], grantQ[3]);
    end
    testsRun++; if (outQ.size() !== 8) begin testsFailed++; $display("[TB] FAIL rr_words got %0d want 8", outQ.size()); end
  endtask

  task automatic test_stall();
    bit timedOut;
    int acksBefore, wordsBefore;
    clearLog();
    remaining[1] = 6; sent[1] = 0;
    applyStimulus();
    for (int n = 0; n < 50 && outQ.size() < 2; n++) cycle();
    dready = 1'b0;
    acksBefore = ackTotal; wordsBefore = outQ.size();
    repeat (10) cycle();
    testsRun++; if (ackTotal !== acksBefore) begin testsFailed++; $display("[TB] FAIL stall_ack got %0d want %0d", ackTotal, acksBefore); end
    testsRun++; if (outQ.size() !== wordsBefore) begin testsFailed++; $display("[TB] FAIL stall_dvalid got %0d want %0d", outQ.size(), wordsBefore); end
    dready = 1'b1;
    drain(100, timedOut);
    testsRun++; if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_timeout got 1 want 0"); end
    testsRun++; if (outQ.size() !== 6 || ackCount[1] !== 6) begin testsFailed++; $display("[TB] FAIL stall_count got %0d/%0d want 6/6", outQ.size(), ackCount[1]); end
    for (int i = 0; i < 6; i++) begin
      testsRun++; if (outQ[i] !== wordOf(i)) begin testsFailed++; $display("[TB] FAIL stall_word[%0d] got %h want %h", i, outQ[i], wordOf(i)); end
    end
  endtask

  task automatic test_maxlen();
    bit timedOut;
    useSmall = 1'b1;
    doReset();
    clearLog();
    remaining[4] = 10; sent[4] = 0;
    applyStimulus();
    drain(100, timedOut);
    testsRun++; if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL maxlen_timeout got 1 want 0"); end
    testsRun++; if (outQ.size() !== 10) begin testsFailed++; $display("[TB] FAIL maxlen_words got %0d want 10", outQ.size()); end
    for (int i = 0; i < 10; i++) begin
      testsRun++; if (firstQ[i] !== (i == 0 || i == 4 || i == 8)) begin testsFailed++; $display("[TB] FAIL maxlen_first[%0d] got %b", i, firstQ[i]); end
      testsRun++; if (outQ[i] !== wordOf(i)) begin testsFailed++; $display("[TB] FAIL maxlen_word[%0d] got %h want %h", i, outQ[i], wordOf(i)); end
    end
    testsRun++; if (overlenCount !== 2) begin testsFailed++; $display("[TB] FAIL maxlen_overlen_count got %0d want 2", overlenCount); end
    testsRun++; if (overlenAt[0] !== 4 || overlenAt[1] !== 8) begin testsFailed++; $display("[TB] FAIL maxlen_overlen_pos got %0d,%0d want 4,8", overlenAt[0], overlenAt[1]); end
    useSmall = 1'b0;
  endtask

  task automatic test_enable();
    bit maskedGranted = 1'b0;
    clearLog();
    enable = 16'hFFFB;
    remaining[2] = 3; remaining[7] = 3; sent[2] = 0; sent[7] = 0;
    applyStimulus();
    for (int n = 0; n < 40; n++) begin
      cycle();
      // Dropping the granted channel's enable mid-block must not cut it short.
      if (!maskedGranted && busyS && gntS == 6'd7) begin enable = 16'hFF7B; maskedGranted = 1'b1; end
    end
    testsRun++; if (ackCount[2] !== 0 || remaining[2] !== 3) begin testsFailed++; $display("[TB] FAIL enable_masked got %0d acks want 0", ackCount[2]); end
    testsRun++; if (ackCount[7] !== 3) begin testsFailed++; $display("[TB] FAIL enable_ch7 got %0d want 3", ackCount[7]); end
    testsRun++; if (grantQ.size() !== 1 || grantQ[0] !== 7) begin testsFailed++; $display("[TB] FAIL enable_grant got %0d grants first %0d want 1 of 7", grantQ.size(), grantQ[0]); end
    remaining[2] = 0;
    enable = 16'hFFFF;
    applyStimulus();
    repeat (3) cycle();
  endtask

  task automatic test_reset_mid_block();
    bit timedOut;
    clearLog();
    remaining[6] = 5; sent[6] = 0;
    applyStimulus();
    for (int n = 0; n < 50 && ackTotal < 2; n++) cycle();
    testsRun++; if (busy1 !== 1'b1 || dvalid1 !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_pre got %b%b want 11", busy1, dvalid1); end
    #2 reset = 1'b1;
    #1;
    testsRun++; if (ack1 !== 16'd0 || dvalid1 !== 1'b0 || busy1 !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL midreset_outputs got ack=%h dvalid=%b busy=%b want 0", ack1, dvalid1, busy1);
    end
    testsRun++; if (gnt1 !== 6'd15) begin testsFailed++; $display("[TB] FAIL midreset_gnt got %0d want 15", gnt1); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clearLog();
    remaining[6] = 5; sent[6] = 0;
    applyStimulus();
    drain(100, timedOut);
    testsRun++; if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_timeout got 1 want 0"); end
    testsRun++; if (outQ.size() !== 5 || outQ[0] !== 16'h8555 || firstQ[0] !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL midreset_restart got %0d words first %h/%b want 5 8555/1", outQ.size(), outQ[0], firstQ[0]);
    end
    testsRun++; if (grantQ.size() !== 1 || grantQ[0] !== 6) begin testsFailed++; $display("[TB] FAIL midreset_grant got %0d", grantQ[0]); end
  endtask

  task automatic test_ack_onehot();
    testsRun++; if (ackViol !== 0) begin testsFailed++; $display("[TB] FAIL ack_onehot got %0d violations want 0", ackViol); end
  endtask

  initial begin
    reset = 1'b1; enable = 16'hFFFF; req = '0; din = '0; dready = 1'b1;
    clearLog();
    test_reset();
    test_single_channel();
    test_ack_onehot();
    test_round_robin();
    test_ack_onehot();
    test_stall();
    test_maxlen();
    test_ack_onehot();
    test_enable();
    test_ack_onehot();
    test_reset_mid_block();
    test_ack_onehot();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/readout_arbiter.md
Name: readout_arbiter

Overview:
- Round-robin arbiter that shares the single readout path among NCH channel processors.
- Each processor presents a 16-bit word on its dout with a req/ack handshake.
- The arbiter grants one channel for a whole block. It drains the block word by word using one-cycle ack pulses, then forwards the words to the downstream event builder as a valid-qualified stream with a block-start marker.
- It sits between the per-channel processors and the output FIFO.

Parameters:
- NCH, 16, number of channel processors (2..64).
- MAXLEN, 1023, maximum words per granted block before forced release.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  NCH  per-channel readout enable mask; 0 = channel never granted.
- req  in  NCH  channel has a valid word on its din slice; held high for the whole block.
- din  in  16*NCH  channel words; slice k = din[16k+15:16k].
- ack  out  NCH  one-cycle pulse; word on din slice consumed.
- dout  out  16  forwarded word.
- dvalid  out  1  dout valid, single-cycle per word.
- dfirst  out  1  qualifies the first word of a block (with dvalid).
- dready  in  1  downstream can accept a word (FIFO not almost full).
- busy  out  1  a channel is currently granted.
- gnt  out  6  index of the granted or last granted channel.
- overlen  out  1  one-cycle pulse on forced release at MAXLEN.

Behaviour:
- Reset (async) sets ack=0, dout=0, dvalid=0, dfirst=0, busy=0, gnt=NCH-1, overlen=0, state=IDLE, word counter=0.
- State IDLE:
  - Compute eligible = req & enable.
  - If nonzero, select the first set bit searching gnt+1, gnt+2, … wrapping modulo NCH. Load gnt, set busy=1, set the first flag, clear the word counter, go to GRANT.
  - If zero, stay in IDLE.
- State GRANT:
  - If req[gnt]=0: end of block. busy=0, go to IDLE. gnt keeps its value, which serves as the round-robin pointer.
  - Else if dready=1: ack[gnt]=1 for this one cycle. Register dout=din slice gnt. Set dvalid=1 and dfirst=first flag on the next cycle. Clear the first flag, increment the counter, go to WAIT.
  - Else hold in GRANT with no ack.
- State WAIT:
  - One dead cycle so the channel can update req/din after ack. ack=0.
  - If counter==MAXLEN: pulse overlen, busy=0, go to IDLE (forced release; channel continues in its next grant, first flag set again).
  - Else go to GRANT.
- Throughput and latency:
  - Peak rate is 1 word per 2 clocks.
  - Latency from req rising in IDLE to first ack is 2 clocks (IDLE→GRANT, ack issued in GRANT).
  - dvalid follows its ack by exactly 1 clock.
- Mask and enable rules:
  - At most one ack bit is high in any cycle, and it is always ack[gnt].
  - enable is sampled only in IDLE. Clearing enable of the granted channel does not abort its block.
- Simultaneous events:
  - req drop and dready in the same GRANT cycle: end of block wins, no ack.
  - Several channels requesting: strict round robin; a channel is granted again only after all other eligible channels have had a turn.
  - req[gnt] falling while in WAIT: ignored until GRANT samples it.
- Reset mid-block: all outputs return to reset values immediately. A partially read channel is regranted later and is expected to restart its block itself.
- Widths:
  - The word counter is 10 bits, clog2(MAXLEN+1).
  - gnt is 6 bits; upper bits are 0 when NCH<64.

Decomposition:
- Shared package holds:
  - State encoding IDLE/GRANT/WAIT.
  - Word width 16.
  - Max channel count 64.
- One natural sub-module: rr_pick, a combinational round-robin priority encoder. It takes eligible[NCH] and a start pointer, and returns the found flag and the index. It is reused by other arbiters in the design.

Test Plan:
- Single channel 3: req high for 4 words, dready=1.
  - Expect acks on clk 2, 4, 6, 8 after req.
  - Expect dvalid one clock later with din values 0x8555, 0x0001, 0x0002, 0x0003; dfirst only with 0x8555.
  - Expect busy to fall after req drops.
- Channels 0, 5, 9 requesting 2-word blocks simultaneously, gnt reset to 15.
  - Expect grant order 0, 5, 9.
  - Rerequest of 0 during 5's block is served after 9.
- dready low for 10 clocks mid-block.
  - Expect no ack and no dvalid during the stall.
  - Expect the block to resume with no lost or duplicated word; word count is 6 in and 6 out.
- MAXLEN=4 build, channel holds req for 10 words.
  - Expect overlen pulse after the 4th word, then regrant.
  - Expect dfirst on words 1, 5 and 9.
- enable=0 on channel 2 while req[2]=1 and req[7]=1: only 7 is granted; req[2] is never acked.
- Assert reset during WAIT after 2 words.
  - Expect ack/dvalid/busy=0 in the same cycle.
  - After release, the block restarts with a dfirst word.
